// File: rtl/fp16_norm_round.sv
// Sequential normalizer and rounder that packs a raw multiply-add magnitude into IEEE FP16.
// Define FP16_NORM_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fp16_norm_round #(
    parameter int IN_WIDTH  = 22,
    parameter int EXP_WIDTH = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sign,
    input  logic [EXP_WIDTH-1:0] expIn,
    input  logic [IN_WIDTH-1:0]  mantIn,
    output logic [15:0]          fpOut,
    output logic                 done,
    output logic                 busy,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int EW = EXP_WIDTH + 2;
    localparam int BW = EW + 1;
    localparam logic signed [BW-1:0] EXP_OVF = BW'(31);
    localparam logic signed [BW-1:0] EXP_ONE = BW'(1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IN_WIDTH-1:0]    shreg;
    logic signed [EW-1:0]   exp_reg;
    logic                   sign_reg;
    logic [15:0]            fp_reg;
    logic                   ovf_reg;
    logic                   unf_reg;

    logic                   is_zero;
    logic                   norm_done;
    logic                   round_up;
    logic                   carry;
    logic [9:0]             frac;
    logic signed [BW-1:0]   bexp;
    logic [15:0]            fp_calc;
    logic                   ovf_calc;
    logic                   unf_calc;

    assign is_zero   = ~|shreg;
    assign norm_done = shreg[IN_WIDTH-1] | is_zero;

`ifdef FP16_NORM_RNE_EN
    logic guard;
    logic sticky;
    assign guard    = shreg[IN_WIDTH-12];
    assign sticky   = |shreg[IN_WIDTH-13:0];
    assign round_up = guard & (sticky | shreg[IN_WIDTH-11]);
`else
    assign round_up = 1'b0;
`endif

    // Hidden bit is always 1 once normalized, so a carry out only happens when the fraction is all ones
    // and then the wrapped fraction is already 0.
    always_comb begin
        carry    = round_up & (&shreg[IN_WIDTH-2 -: 10]);
        frac     = shreg[IN_WIDTH-2 -: 10] + 10'(round_up);
        bexp     = {exp_reg[EW-1], exp_reg} + BW'(15) + BW'(carry);
        fp_calc  = {sign_reg, 15'b0};
        ovf_calc = 1'b0;
        unf_calc = 1'b0;
        if (is_zero) begin
            fp_calc = {sign_reg, 15'b0};
        end else if (bexp >= EXP_OVF) begin
            fp_calc  = {sign_reg, 5'h1F, 10'b0};
            ovf_calc = 1'b1;
        end else if (bexp < EXP_ONE) begin
            fp_calc  = {sign_reg, 15'b0};
            unf_calc = 1'b1;
        end else begin
            fp_calc = {sign_reg, bexp[4:0], frac};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = NORM;
            NORM:    if (norm_done) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            exp_reg  <= '0;
            sign_reg <= 1'b0;
            fp_reg   <= '0;
            ovf_reg  <= 1'b0;
            unf_reg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_reg <= sign;
                        shreg    <= mantIn;
                        exp_reg  <= {{2{expIn[EXP_WIDTH-1]}}, expIn} + EW'(1);
                        ovf_reg  <= 1'b0;
                        unf_reg  <= 1'b0;
                    end
                end
                NORM: begin
                    if (!norm_done) begin
                        shreg   <= {shreg[IN_WIDTH-2:0], 1'b0};
                        exp_reg <= exp_reg - EW'(1);
                    end
                end
                ROUND: begin
                    fp_reg  <= fp_calc;
                    ovf_reg <= ovf_calc;
                    unf_reg <= unf_calc;
                end
                default: ;
            endcase
        end
    end

    assign fpOut     = fp_reg;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp16_norm_round.sv
// Scoreboard bench for fp16_norm_round: expected results come from an arithmetic FP16 model.
// Honours FP16_NORM_RNE_EN the same way the design does.
module tb_fp16_norm_round;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sign;
    logic [6:0]  expIn;
    logic [21:0] mantIn;
    logic [15:0] fpOut;
    logic        done;
    logic        busy;
    logic        overflow;
    logic        underflow;

    fp16_norm_round #(.IN_WIDTH(22), .EXP_WIDTH(7)) dut (
        .clock(clock), .reset(reset), .start(start), .sign(sign),
        .expIn(expIn), .mantIn(mantIn), .fpOut(fpOut), .done(done),
        .busy(busy), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] fp;
        bit          ovf;
        bit          unf;
        int          lat;
        longint      due;
    } exp_t;

    exp_t   sbq[$];
    exp_t   last;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Value = m * 2^(e-20); normalize to 1.f * 2^E, round to 10 fraction bits.
    function automatic exp_t model(input bit s, input int e, input longint m);
        exp_t   r;
        int     p;
        int     sh;
        int     ee;
        int     b;
        longint kept;
        r.ovf = 0;
        r.unf = 0;
        r.due = 0;
        r.fp  = {s, 15'b0};
        if (m == 0) begin
            r.lat = 3;
            return r;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        r.lat = (21 - p) + 3;
        ee = e + p - 20;
        if (p >= 10) begin
            sh   = p - 10;
            kept = m >> sh;
`ifdef FP16_NORM_RNE_EN
            if (sh > 0) begin
                longint rem;
                longint half;
                rem  = m - (kept << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && kept % 2 == 1)) kept++;
            end
`endif
        end else begin
            kept = m << (10 - p);
        end
        if (kept == 2048) begin
            kept = 1024;
            ee++;
        end
        b = ee + 15;
        if (b >= 31) begin
            r.fp  = {s, 5'h1F, 10'b0};
            r.ovf = 1;
        end else if (b <= 0) begin
            r.unf = 1;
        end else begin
            r.fp = {s, 5'(b), 10'(kept - 1024)};
        end
        return r;
    endfunction

    // delay: negedges between now and the one just before start is sampled
    task automatic issue(input bit s, input int e, input logic [21:0] m, input int delay);
        exp_t x;
        sign   = s;
        expIn  = 7'(e);
        mantIn = m;
        start  = 1'b1;
        x      = model(s, e, longint'(m));
        x.due  = cyc + delay + x.lat;
        last   = x;
        sbq.push_back(x);
    endtask

    task automatic wait_done_raw(input bit chk_busy);
        int k = 0;
        while (!done && k < 100) begin
            if (chk_busy) check("busy_during_op", busy, 1);
            @(negedge clock);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done, expected done within 100 cycles");
        end
    endtask

    task automatic run_op(input bit s, input int e, input logic [21:0] m);
        issue(s, e, m, 0);
        @(negedge clock);
        start = 1'b0;
        wait_done_raw(1'b0);
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (!reset && done) begin
            exp_t x;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
            end else begin
                x = sbq.pop_front();
                check("fpOut", fpOut, x.fp);
                check("overflow", overflow, x.ovf);
                check("underflow", underflow, x.unf);
                check("latency", cyc, x.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        sign   = 1'b0;
        expIn  = '0;
        mantIn = '0;
        repeat (2) @(negedge clock);
        check("reset_fpOut", fpOut, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_overflow", overflow, 0);
        check("reset_underflow", underflow, 0);
        reset = 1'b0;
        @(negedge clock);

        run_op(0, 0, 22'h100000);
        run_op(0, 0, 22'h200C00);
        run_op(0, 0, 22'h200400);
        run_op(0, 15, 22'h200000);
        repeat (3) @(negedge clock);
        check("overflow_held", overflow, 1);
        check("fpOut_held", fpOut, last.fp);
        run_op(0, -17, 22'h200000);
        run_op(1, 0, 22'h000000);
        run_op(0, -2, 22'h3FFFFF);
        run_op(1, -14, 22'h3FFC00);

        // long normalization with an ignored mid-operation start
        issue(0, 20, 22'h000001, 0);
        @(negedge clock);
        start = 1'b0;
        repeat (5) begin
            check("busy_long", busy, 1);
            @(negedge clock);
        end
        start  = 1'b1;
        mantIn = 22'h3FFFFF;
        expIn  = 7'd3;
        @(negedge clock);
        start = 1'b0;
        wait_done_raw(1'b1);
        @(negedge clock);

        // start held through DONE launches the next operation from IDLE
        issue(0, 3, 22'h0ABCDE, 0);
        wait_done_raw(1'b0);
        issue(1, -5, 22'h1F0F0F, 1);
        @(negedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done_raw(1'b0);
        @(negedge clock);

        // reset in the middle of normalization
        run_op(0, 0, 22'h100000);
        issue(0, 20, 22'h000001, 0);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_fpOut", fpOut, 0);
        sbq.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_op(1, 1, 22'h180000);

        for (int i = 0; i < 60; i++) begin
            logic [21:0] m;
            m = 22'($urandom) >> $urandom_range(0, 22);
            run_op(1'($urandom), int'($urandom_range(0, 80)) - 40, m);
        end

        check("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
